// File: rtl/stream_fifo_multichan.sv
// -----------------------------------------------------------------------------
// stream_fifo_multichan
//
// NumChan independent ready/valid input channels. Each channel is buffered in
// its own Depth-entry FIFO. The channels are merged onto one ready/valid output
// by a round-robin arbiter that locks onto the presented channel until its
// beat is taken.
//
// Ports
//   clk_i    : clock, single domain
//   rst_i    : synchronous active-high reset
//   flush_i  : per-channel flush, empties the channel at the next edge
//   valid_i  : per-channel input valid
//   ready_o  : per-channel input ready (!full && !rst_i)
//   data_i   : per-channel input payload
//   valid_o  : output valid
//   ready_i  : output ready
//   data_o   : output payload (0 when valid_o=0)
//   chan_o   : source channel of data_o (0 when valid_o=0)
//   usage_o  : per-channel occupancy
// -----------------------------------------------------------------------------
module stream_fifo_multichan #(
    parameter int unsigned NumChan   = 4,
    parameter int unsigned Depth     = 8,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdxWidth  = (NumChan > 1) ? $clog2(NumChan) : 1,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumChan-1:0]                  flush_i,
    input  logic [NumChan-1:0]                  valid_i,
    output logic [NumChan-1:0]                  ready_o,
    input  logic [NumChan-1:0][DataWidth-1:0]   data_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [DataWidth-1:0]                data_o,
    output logic [IdxWidth-1:0]                 chan_o,
    output logic [NumChan-1:0][CntWidth-1:0]    usage_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [IdxWidth-1:0] LastChan = IdxWidth'(NumChan - 1);
    localparam logic [CntWidth-1:0] FullCnt  = CntWidth'(Depth);

    logic [DataWidth-1:0]               mem_r [NumChan][Depth];
    logic [NumChan-1:0][PtrWidth-1:0]   rd_ptr_r;
    logic [NumChan-1:0][PtrWidth-1:0]   wr_ptr_r;
    logic [NumChan-1:0][CntWidth-1:0]   usage_r;
    logic [IdxWidth-1:0]                rr_ptr_r;
    logic [IdxWidth-1:0]                lock_chan_r;
    logic                               lock_valid_r;

    logic [NumChan-1:0]                 empty_s;
    logic [NumChan-1:0]                 ready_s;
    logic [NumChan-1:0]                 push_s;
    logic [IdxWidth-1:0]                sel_s;
    logic                               found_s;
    logic                               valid_s;
    logic                               pop_s;

    // Per-channel status derived purely from the occupancy counters.
    always_comb begin
        for (int c = 0; c < NumChan; c++) begin
            empty_s[c] = (usage_r[c] == CntWidth'(0));
            ready_s[c] = (usage_r[c] != FullCnt) && !rst_i;
            push_s[c]  = valid_i[c] && ready_s[c];
        end
    end

    // Channel selection: a held lock wins; otherwise the first non-empty
    // channel at or after the round-robin pointer.
    always_comb begin
        sel_s   = {IdxWidth{1'b0}};
        found_s = 1'b0;
        if (lock_valid_r) begin
            sel_s   = lock_chan_r;
            found_s = 1'b1;
        end else begin
            for (int i = 0; i < NumChan; i++) begin
                if (!found_s && !empty_s[(int'(rr_ptr_r) + i) % NumChan]) begin
                    sel_s   = IdxWidth'((int'(rr_ptr_r) + i) % NumChan);
                    found_s = 1'b1;
                end else begin
                    sel_s   = sel_s;
                end
            end
        end
    end

    // A locked channel is never empty (pop and flush both release the lock),
    // so emptiness of the selected channel alone decides valid.
    assign valid_s = found_s && !empty_s[sel_s];
    assign pop_s   = valid_s && ready_i;

    // Output drive; payload and index are forced to zero when idle.
    always_comb begin
        valid_o = valid_s;
        ready_o = ready_s;
        usage_o = usage_r;
        if (valid_s) begin
            data_o = mem_r[sel_s][rd_ptr_r[sel_s]];
            chan_o = sel_s;
        end else begin
            data_o = {DataWidth{1'b0}};
            chan_o = {IdxWidth{1'b0}};
        end
    end

    // Storage write port; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumChan; c++) begin
            if (push_s[c] && !flush_i[c]) begin
                mem_r[c][wr_ptr_r[c]] <= data_i[c];
            end
        end
    end

    // Per-channel pointers and occupancy; flush overrides push and pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            usage_r  <= '0;
        end else begin
            for (int c = 0; c < NumChan; c++) begin
                if (flush_i[c]) begin
                    rd_ptr_r[c] <= PtrWidth'(0);
                    wr_ptr_r[c] <= PtrWidth'(0);
                    usage_r[c]  <= CntWidth'(0);
                end else begin
                    if (push_s[c]) begin
                        wr_ptr_r[c] <= (wr_ptr_r[c] == LastPtr) ? PtrWidth'(0)
                                                                : wr_ptr_r[c] + PtrWidth'(1);
                    end
                    if (pop_s && (sel_s == IdxWidth'(c))) begin
                        rd_ptr_r[c] <= (rd_ptr_r[c] == LastPtr) ? PtrWidth'(0)
                                                                : rd_ptr_r[c] + PtrWidth'(1);
                    end
                    case ({push_s[c], pop_s && (sel_s == IdxWidth'(c))})
                        2'b10:   usage_r[c] <= usage_r[c] + CntWidth'(1);
                        2'b01:   usage_r[c] <= usage_r[c] - CntWidth'(1);
                        default: usage_r[c] <= usage_r[c];
                    endcase
                end
            end
        end
    end

    // Round-robin pointer and output lock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_r     <= {IdxWidth{1'b0}};
            lock_chan_r  <= {IdxWidth{1'b0}};
            lock_valid_r <= 1'b0;
        end else if (pop_s) begin
            rr_ptr_r     <= (sel_s == LastChan) ? {IdxWidth{1'b0}} : sel_s + IdxWidth'(1);
            lock_valid_r <= 1'b0;
        end else if (valid_s && flush_i[sel_s]) begin
            lock_valid_r <= 1'b0;
        end else if (valid_s) begin
            lock_valid_r <= 1'b1;
            lock_chan_r  <= sel_s;
        end else begin
            lock_valid_r <= 1'b0;
        end
    end

    stream_fifo_multichan_chk #(
        .NumChan   (NumChan),
        .Depth     (Depth),
        .DataWidth (DataWidth),
        .IdxWidth  (IdxWidth),
        .CntWidth  (CntWidth)
    ) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .chan_o  (chan_o),
        .usage_o (usage_o)
    );

endmodule

// -----------------------------------------------------------------------------
// stream_fifo_multichan_chk
//
// Property checker: output stability under back-pressure (waived when the
// presented channel is flushed) and occupancy bound.
// Ports mirror the observed signals of stream_fifo_multichan.
// -----------------------------------------------------------------------------
module stream_fifo_multichan_chk #(
    parameter int unsigned NumChan   = 4,
    parameter int unsigned Depth     = 8,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdxWidth  = 2,
    parameter int unsigned CntWidth  = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumChan-1:0]                  flush_i,
    input  logic                                valid_o,
    input  logic                                ready_i,
    input  logic [DataWidth-1:0]                data_o,
    input  logic [IdxWidth-1:0]                 chan_o,
    input  logic [NumChan-1:0][CntWidth-1:0]    usage_o
);

    logic                   hold_r;
    logic [IdxWidth-1:0]    hold_chan_r;
    logic [DataWidth-1:0]   hold_data_r;

    // Remember a stalled beat and require it unchanged in the following cycle.
    always_ff @(posedge clk_i) begin
        if (hold_r) begin
            assert (valid_o && (chan_o == hold_chan_r) && (data_o == hold_data_r));
        end
        for (int c = 0; c < NumChan; c++) begin
            assert (usage_o[c] <= CntWidth'(Depth));
        end
        if (rst_i) begin
            hold_r <= 1'b0;
        end else begin
            hold_r      <= valid_o && !ready_i && !flush_i[chan_o];
            hold_chan_r <= chan_o;
            hold_data_r <= data_o;
        end
    end

endmodule
